alu_share_ctrl: RTL and testbench

//  Shares one combinational ALU (5-bit Op, 32-bit A/B) between two requesters:

---
 rtl/alu_ctrl_pkg.sv | 39 +++
 rtl/rr_arb2.sv | 24 ++
 rtl/alu_share_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: op encodings,
// op classification helpers and the controller FSM encoding.
package alu_ctrl_pkg;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_XOR    = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_SLT    = 5'b00111;
  localparam logic [4:0] OP_SRA    = 5'b01000;
  localparam logic [4:0] OP_SLTU   = 5'b01001;
  localparam logic [4:0] OP_NOR    = 5'b01010;
  localparam logic [4:0] OP_LUI    = 5'b01100;
  localparam logic [4:0] OP_NAND   = 5'b01110;
  localparam logic [4:0] OP_ADDF   = 5'b01111;
  localparam logic [4:0] OP_CVTI2F = 5'b11110;
  localparam logic [4:0] OP_CVTF2I = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // FP-class ops need the long settle time through the ALU.
  function automatic logic is_fp(input logic [4:0] op);
    return (op == OP_ADDF) || (op == OP_CVTI2F) || (op == OP_CVTF2I);
  endfunction

  // Unassigned encodings; the ALU falls back to its default add for these.
  function automatic logic is_illegal(input logic [4:0] op);
    return (op == 5'b01011) || (op == 5'b01101) ||
           ((op >= 5'b10000) && (op <= 5'b11101));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// port that did not win last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] grant,
  output logic       grant_id,
  output logic       grant_any
);

  always_comb begin
    grant_id  = 1'b0;
    grant_any = |req;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~rr_last;
      default: grant_id = 1'b0;
    endcase
    grant = 2'b00;
    if (grant_any) grant = grant_id ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between the integer EX stage (port 0) and
// the FP/convert sequencer (port 1), holding operands for the settle time.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  ST_IDLE | waiting for a request; grant offered combinationally
//  ST_EXEC | operands held on ALU, settle counter running down
//  ST_RESP | captured result presented until rsp_ready
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W       = 32,
  parameter int INT_LAT = 1,
  parameter int FP_LAT  = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [4:0]       req_op0,
  input  logic [4:0]       req_op1,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b0,
  input  logic [W-1:0]     req_b1,
  output logic [4:0]       alu_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] busy_cycles
);

  localparam int MAX_LAT = (FP_LAT > INT_LAT) ? FP_LAT : INT_LAT;
  localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] cnt;
  logic             settle_done;
  logic             rr_last;
  logic             id_q;
  logic             illegal_q;
  logic [4:0]       op_q;
  logic [W-1:0]     a_q, b_q, res_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] busy_cnt;

  logic [1:0]       grant;
  logic             grant_id, grant_any;
  logic [4:0]       op_sel;
  logic [W-1:0]     a_sel, b_sel;

  rr_arb2 u_arb (
    .req       (req_valid),
    .rr_last   (rr_last),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  assign op_sel      = grant_id ? req_op1 : req_op0;
  assign a_sel       = grant_id ? req_a1  : req_a0;
  assign b_sel       = grant_id ? req_b1  : req_b0;
  assign settle_done = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_any)   state_nxt = ST_EXEC;
      ST_EXEC: if (settle_done) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is masked during reset so every output reads zero there.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: if (!reset) req_ready = grant;
      ST_EXEC: busy = 1'b1;
      ST_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU operand regs only load on grant, so the ALU inputs never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rr_last   <= 1'b1;
      id_q      <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (grant_any) begin
          op_q      <= op_sel;
          a_q       <= a_sel;
          b_q       <= b_sel;
          id_q      <= grant_id;
          illegal_q <= is_illegal(op_sel);
          cnt       <= is_fp(op_sel) ? LAT_W'(FP_LAT - 1) : LAT_W'(INT_LAT - 1);
        end
        ST_EXEC: begin
          if (settle_done) begin
            res_q   <= alu_result;
            flags_q <= alu_flags;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        ST_RESP: if (rsp_ready) rr_last <= id_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 busy_cnt <= '0;
    else if (state != ST_IDLE) busy_cnt <= busy_cnt + CNT_W'(1);
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp_id      = id_q;
  assign rsp_result  = res_q;
  assign rsp_flags   = flags_q;
  assign rsp_illegal = illegal_q;
  assign busy_cycles = busy_cnt;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized bench for alu_share_ctrl: a behavioural ALU drives the DUT's
// ALU port, and a transaction-level model predicts grants, latency and responses.
module tb_alu_share_ctrl;

  localparam int W       = 32;
  localparam int INT_LAT = 1;
  localparam int FP_LAT  = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready;
  logic [4:0]       req_op0, req_op1, alu_op;
  logic [W-1:0]     req_a0, req_a1, req_b0, req_b1;
  logic [W-1:0]     alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]       alu_flags, rsp_flags;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_illegal, busy;
  logic [CNT_W-1:0] busy_cycles;

  int n_vec = 0;
  int n_err = 0;

  // requester-side model state
  logic        pend [2];
  logic [4:0]  mop  [2];
  logic [31:0] ma   [2];
  logic [31:0] mb   [2];
  logic        rr_last;
  int          bc;
  logic        rearm;
  logic [31:0] last_res;
  logic [3:0]  last_flags;
  logic        last_illegal;

  alu_share_ctrl #(.W(W), .INT_LAT(INT_LAT), .FP_LAT(FP_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal),
    .busy(busy), .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i2f(input logic [31:0] a);
    logic [31:0] mag, man;
    int p;
    if (a == 32'd0) return 32'd0;
    mag = a[31] ? (~a + 32'd1) : a;
    p = 31;
    while (!mag[p]) p--;
    man = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
    return {a[31], 8'(127 + p), man[22:0]};
  endfunction

  // {Set, Zero, Carryout, Overflow, Result}
  function automatic logic [35:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'b00111: r = {31'd0, $signed(a) < $signed(b)};
      5'b01111: r = a ^ b;
      5'b11110: r = i2f(a);
      5'b11111: r = {1'b0, a[30:0]} >> 4;
      default: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
    endcase
    return {$signed(a) < $signed(b), r == 32'd0, c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = ref_alu(alu_op, alu_a, alu_b);

  function automatic logic ref_illegal(input logic [4:0] op);
    return (op == 5'd11) || (op == 5'd13) || (op >= 5'd16 && op <= 5'd29);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_req(input int p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[p] = 1'b1;
    mop[p]  = op;
    ma[p]   = a;
    mb[p]   = b;
  endtask

  task automatic rand_req(input int p);
    logic [4:0] op;
    logic [4:0] common [8];
    common = '{5'b00010, 5'b00110, 5'b00111, 5'b00000, 5'b00001, 5'b01111, 5'b11110, 5'b11111};
    if ($urandom_range(0, 1) == 1) op = common[$urandom_range(0, 7)];
    else                           op = 5'($urandom_range(0, 31));
    new_req(p, op, $urandom, ($urandom_range(0, 3) == 0) ? ma[p] : $urandom);
  endtask

  task automatic drive_reqs();
    req_valid = {pend[1], pend[0]};
    req_op0 = mop[0]; req_a0 = ma[0]; req_b0 = mb[0];
    req_op1 = mop[1]; req_a1 = ma[1]; req_b1 = mb[1];
  endtask

  task automatic idle_cycle();
    drive_reqs();
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  // One request/response exchange; entered at a negedge with the DUT idle.
  task automatic txn(input int stall);
    int g, lat, edges;
    logic [4:0] op;
    logic [31:0] a, b;
    logic [35:0] exp;
    drive_reqs();
    rsp_ready = (stall == 0);
    #1;
    g = (pend[0] && pend[1]) ? int'(!rr_last) : (pend[1] ? 1 : 0);
    chk("grant", 64'(req_ready), (g == 1) ? 64'd2 : 64'd1);
    op  = mop[g];
    a   = ma[g];
    b   = mb[g];
    lat = (op == 5'b01111 || op == 5'b11110 || op == 5'b11111) ? FP_LAT : INT_LAT;
    exp = ref_alu(op, a, b);
    pend[g] = 1'b0;
    @(negedge clk);
    edges = 1;
    if (rearm && $urandom_range(0, 1) == 1) rand_req(g);
    drive_reqs();
    #1;
    while (!rsp_valid && edges < 12) begin
      chk("exec_ready", 64'(req_ready), 64'd0);
      chk("exec_busy", 64'(busy), 64'd1);
      chk("exec_alu_a", 64'(alu_a), 64'(a));
      chk("exec_alu_opb", 64'({alu_op, alu_b}), 64'({op, b}));
      @(negedge clk);
      #1;
      edges++;
    end
    chk("latency", 64'(edges), 64'(lat + 1));
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_result", 64'(rsp_result), 64'(exp[31:0]));
      chk("stall_flags", 64'({rsp_id, rsp_flags}), 64'({g[0], exp[35:32]}));
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("rsp_result", 64'(rsp_result), 64'(exp[31:0]));
    chk("rsp_flags", 64'(rsp_flags), 64'(exp[35:32]));
    chk("rsp_illegal", 64'(rsp_illegal), 64'(ref_illegal(op)));
    chk("resp_alu_a", 64'(alu_a), 64'(a));
    chk("resp_ready", 64'(req_ready), 64'd0);
    last_res     = rsp_result;
    last_flags   = rsp_flags;
    last_illegal = rsp_illegal;
    @(negedge clk);
    rsp_ready = 1'b0;
    rr_last   = g[0];
    bc        = (bc + lat + 1 + stall) % 16;
    #1;
    chk("rsp_done", 64'(rsp_valid), 64'd0);
    chk("busy_cycles", 64'(busy_cycles), 64'(bc));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_busy_cycles", 64'(busy_cycles), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_outs", 64'({alu_op, rsp_id, rsp_illegal, rsp_flags}), 64'd0);
    chk("rst_data", 64'({alu_a, rsp_result}), 64'd0);
    @(negedge clk);
    reset   = 1'b0;
    rr_last = 1'b1;
    bc      = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; mop[p] = '0; ma[p] = '0; mb[p] = '0;
    end
    rearm     = 1'b0;
    rsp_ready = 1'b0;
    reset     = 1'b1;
    drive_reqs();
    @(negedge clk);
    @(negedge clk);
    apply_reset();

    // reset while a response is waiting
    new_req(0, 5'b00010, 32'd9, 32'd1);
    drive_reqs();
    @(negedge clk);
    pend[0] = 1'b0;
    drive_reqs();
    @(negedge clk);
    #1;
    chk("pre_reset_resp", 64'(rsp_valid), 64'd1);
    apply_reset();

    // port 0 ADD 5+7
    new_req(0, 5'b00010, 32'd5, 32'd7);
    txn(0);
    chk("add_result", 64'(last_res), 64'd12);
    chk("add_zero", 64'(last_flags[2]), 64'd0);

    // port 1 CVTI2F 1
    new_req(1, 5'b11110, 32'd1, 32'd0);
    txn(0);
    chk("cvt_result", 64'(last_res), 64'h3F800000);

    // both ports SUB 3-3, alternating grants
    for (int i = 0; i < 8; i++) begin
      if (!pend[0]) new_req(0, 5'b00110, 32'd3, 32'd3);
      if (!pend[1]) new_req(1, 5'b00110, 32'd3, 32'd3);
      txn(0);
      chk("sub_zero", 64'(last_flags[2]), 64'd1);
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // long response stall
    new_req(0, 5'b00001, $urandom, $urandom);
    txn(10);

    // unassigned op falls back to add
    new_req(0, 5'b10000, 32'd1, 32'd2);
    txn(0);
    chk("illegal_result", 64'(last_res), 64'd3);
    chk("illegal_flag", 64'(last_illegal), 64'd1);

    // busy_cycles wraps after 16 busy cycles
    idle_cycle();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      new_req(int'(i % 2), 5'b00010, $urandom, $urandom);
      txn(0);
    end
    chk("busy_wrap", 64'(busy_cycles), 64'd0);

    // randomized traffic
    rearm = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) != 0) rand_req(p);
      if (!pend[0] && !pend[1]) idle_cycle();
      else if ($urandom_range(0, 7) == 0) begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle_cycle();
      end else txn($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
